// File: rtl/router_pkg.sv
// Shared router constants and flit types, imported by the input and output channels.
// A flit value of all zeros means "no flit".
package router_pkg;
  localparam int FLIT_W            = 64;
  localparam int NUM_VC            = 2;
  localparam int AGE_W             = 16;
  localparam int DEFAULT_AGE_LIMIT = 255;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [AGE_W-1:0]  age_t;

  localparam flit_t EMPTY_FLIT = '0;

  function automatic logic is_flit(input flit_t f);
    return f != EMPTY_FLIT;
  endfunction
endpackage

// File: rtl/router_vc_slot.sv
// One virtual-channel slot: a single flit register, its valid bit and a
// saturating age counter that reports when the held flit reaches AGE_LIMIT.
module router_vc_slot
  import router_pkg::*;
#(
  parameter int AGE_LIMIT = DEFAULT_AGE_LIMIT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_load,
  input  flit_t i_data,
  input  logic  i_clear,
  output logic  o_valid,
  output flit_t o_data,
  output logic  o_aged
);
  localparam age_t AGE_MAX = age_t'(AGE_LIMIT);

  logic  r_valid;
  flit_t r_data;
  age_t  r_age;
  age_t  w_age_next;

  // Age restarts on load or clear and only counts while the same flit stays put.
  always_comb begin
    w_age_next = '0;
    if (r_valid && !i_load && !i_clear) begin
      w_age_next = (r_age == AGE_MAX) ? r_age : r_age + age_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= EMPTY_FLIT;
      r_age   <= '0;
    end else begin
      r_age <= w_age_next;
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (i_clear) begin
        r_valid <= 1'b0;
        r_data  <= EMPTY_FLIT;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_aged  = !reset && r_valid && (w_age_next == AGE_MAX);
endmodule

// File: rtl/router_output_channel.sv
// Router output port with two polarity-steered VC slots: the crossbar writes VC[p]
// while the link drains VC[~p], so write and drain never touch the same slot.
module router_output_channel
  import router_pkg::*;
#(
  parameter int AGE_LIMIT = DEFAULT_AGE_LIMIT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  polarity,
  input  logic  wr_en,
  input  flit_t wr_data,
  output logic  full,
  input  logic  ready_in,
  output logic  send,
  output flit_t data_out,
  output logic  overflow,
  output logic  stall_err
);
  // Handshake: a drain completes at an edge when the drain-side slot holds a flit
  // and ready_in=1; the flit is then presented for exactly one cycle with send=1.

  logic [NUM_VC-1:0] w_valid;
  logic [NUM_VC-1:0] w_aged;
  logic [NUM_VC-1:0] w_load;
  logic [NUM_VC-1:0] w_clear;
  flit_t             w_slot_data [NUM_VC];

  logic  w_wr_sel;
  logic  w_dr_sel;
  logic  w_wr_req;
  logic  w_drain;
  flit_t w_drain_data;

  logic  r_send;
  flit_t r_data_out;
  logic  r_overflow;
  logic  r_stall_err;

  assign w_wr_sel     = polarity;
  assign w_dr_sel     = ~polarity;
  assign w_wr_req     = wr_en && is_flit(wr_data);
  assign w_drain      = w_valid[w_dr_sel] && ready_in;
  assign w_drain_data = w_slot_data[w_dr_sel];

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    assign w_load[gi]  = w_wr_req && (w_wr_sel == 1'(gi)) && !w_valid[gi];
    assign w_clear[gi] = w_drain && (w_dr_sel == 1'(gi));

    router_vc_slot #(
      .AGE_LIMIT(AGE_LIMIT)
    ) u_slot (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load[gi]),
      .i_data (wr_data),
      .i_clear(w_clear[gi]),
      .o_valid(w_valid[gi]),
      .o_data (w_slot_data[gi]),
      .o_aged (w_aged[gi])
    );
  end

  assign full = !reset && w_valid[w_wr_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_send      <= 1'b0;
      r_data_out  <= EMPTY_FLIT;
      r_overflow  <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      r_send      <= w_drain;
      r_data_out  <= w_drain ? w_drain_data : EMPTY_FLIT;
      r_overflow  <= r_overflow | (w_wr_req && w_valid[w_wr_sel]);
      r_stall_err <= r_stall_err | (|w_aged);
    end
  end

  assign send      = r_send;
  assign data_out  = r_data_out;
  assign overflow  = r_overflow;
  assign stall_err = r_stall_err;
endmodule

// File: tb/tb_router_output_channel.sv
// Bench for router_output_channel: directed scenarios plus random traffic, checked
// by a monitor against a slot-level reference model and an expected-flit queue.
module tb_router_output_channel;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        full;
  logic        ready_in;
  logic        send;
  logic [63:0] data_out;
  logic        overflow;
  logic        stall_err;

  router_output_channel #(.AGE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .ready_in (ready_in),
    .send     (send),
    .data_out (data_out),
    .overflow (overflow),
    .stall_err(stall_err)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: what each VC holds and for how long
  logic        m_valid [2];
  logic [63:0] m_data  [2];
  int          m_held  [2];
  logic        m_ovf;
  logic        m_stall;
  logic        m_fire;
  logic [63:0] exp_q[$];

  int   n_checks;
  int   n_fail;
  logic pol;
  logic hold_pol;
  logic mon_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic p, input logic we, input logic [63:0] wd,
                            input logic rdy, input logic rst);
    int wi;
    int di;
    wi = p ? 1 : 0;
    di = p ? 0 : 1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 1'b0;
        m_held[i]  = 0;
      end
      m_ovf   = 1'b0;
      m_stall = 1'b0;
      m_fire  = 1'b0;
      return;
    end
    // flits that stay where they are one more cycle grow older
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] && !(i == di && rdy)) begin
        m_held[i] = (m_held[i] + 1 > LIMIT) ? LIMIT : m_held[i] + 1;
        if (m_held[i] == LIMIT) m_stall = 1'b1;
      end
    end
    m_fire = m_valid[di] && rdy;
    if (m_fire) begin
      exp_q.push_back(m_data[di]);
      m_valid[di] = 1'b0;
      m_held[di]  = 0;
    end
    if (we && wd != 64'h0) begin
      if (m_valid[wi]) m_ovf = 1'b1;
      else begin
        m_valid[wi] = 1'b1;
        m_data[wi]  = wd;
        m_held[wi]  = 0;
      end
    end
  endtask

  // driver: one clock cycle of stimulus, model updated at the same edge
  task automatic tick(input logic we, input logic [63:0] wd, input logic rdy, input logic rst);
    logic p;
    p        = pol;
    reset    = rst;
    polarity = p;
    wr_en    = we;
    wr_data  = wd;
    ready_in = rdy;
    @(posedge clk);
    model_step(p, we, wd, rdy, rst);
    if (rst) mon_en = 1'b1;
    #1;
    if (!hold_pol) pol = ~pol;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 64'h0, rdy, 1'b0);
  endtask

  task automatic align_p0();
    if (pol != 1'b0) idle(1, 1'b1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("full", {63'h0, full}, {63'h0, !reset && m_valid[polarity ? 1 : 0]});
      chk("overflow", {63'h0, overflow}, {63'h0, m_ovf});
      chk("stall_err", {63'h0, stall_err}, {63'h0, m_stall});
      chk("send", {63'h0, send}, {63'h0, m_fire});
      if (send === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", data_out, 64'h0);
        end else begin
          chk("data_out", data_out, exp_q.pop_front());
        end
      end else begin
        chk("idle_data_out", data_out, 64'h0);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pol      = 1'b0;
    hold_pol = 1'b0;
    mon_en   = 1'b0;
    m_fire   = 1'b0;
    m_ovf    = 1'b0;
    m_stall  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 64'h0;
      m_held[i]  = 0;
    end
    reset = 1'b1; polarity = 1'b0; wr_en = 1'b0; wr_data = 64'h0; ready_in = 1'b0;

    tick(1'b0, 64'h0, 1'b0, 1'b1);
    tick(1'b0, 64'h0, 1'b0, 1'b1);

    // single flit through the channel
    align_p0();
    tick(1'b1, 64'hA5, 1'b1, 1'b0);
    idle(4, 1'b1);

    // back-to-back writes into both VCs
    align_p0();
    tick(1'b1, 64'h11, 1'b1, 1'b0);
    tick(1'b1, 64'h22, 1'b1, 1'b0);
    idle(4, 1'b1);

    // overflow on a full VC
    align_p0();
    tick(1'b1, 64'h33, 1'b0, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 1'b0);
    tick(1'b1, 64'h44, 1'b0, 1'b0);
    idle(4, 1'b1);
    tick(1'b0, 64'h0, 1'b0, 1'b1);

    // stall detection while the link is not ready
    align_p0();
    tick(1'b1, 64'h55, 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(4, 1'b1);
    tick(1'b0, 64'h0, 1'b0, 1'b1);

    // zero flits are not flits
    for (int i = 0; i < 6; i++) tick(1'b1, 64'h0, 1'b1, 1'b0);

    // reset discards a held flit
    align_p0();
    tick(1'b1, 64'h77, 1'b0, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 1'b0);
    tick(1'b1, 64'h88, 1'b1, 1'b1);
    idle(4, 1'b1);

    // random traffic, including held polarity and occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic        we, rdy, rst;
      logic [63:0] wd;
      hold_pol = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wd  = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick(we, wd, rdy, rst);
    end
    hold_pol = 1'b0;
    idle(6, 1'b1);
    @(negedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/router_output_channel.md
ROUTER_OUTPUT_CHANNEL -- requirements
Module: router_output_channel

Interface
REQ-001 Parameter AGE_LIMIT, default 255, cycles a flit may stay held in one VC before stall_err is raised (range 1..65535).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 polarity  input  1  global even/odd cycle phase, toggles every cycle, shared with all router channels.
REQ-005 wr_en  input  1  router crossbar presents a flit for this output port.
REQ-006 wr_data  input  64  flit from crossbar; 64'h0 denotes "no flit".
REQ-007 full  output  1  combinational; VC targeted by writes this cycle is occupied.
REQ-008 ready_in  input  1  downstream input channel ready for the VC being drained this cycle.
REQ-009 send  output  1  registered; flit valid on data_out this cycle.
REQ-010 data_out  output  64  registered link flit; 64'h0 whenever send is low.
REQ-011 overflow  output  1  registered sticky; a write was rejected because its VC was full.
REQ-012 stall_err  output  1  registered sticky; a VC held one flit for AGE_LIMIT consecutive cycles.

Function
REQ-013 Two VC slots, VC0 (even) and VC1 (odd), each one 64-bit flit plus valid bit.
REQ-014 Cycle with polarity=p: write side targets VC[p]; drain side targets VC[~p]; write and drain never hit the same slot.
REQ-015 Write: wr_en=1, wr_data!=0, VC[p] empty -> VC[p] loads wr_data at the edge, valid set.
REQ-016 wr_en=1 with wr_data==0 is ignored; no state change, no overflow.
REQ-017 wr_en=1, wr_data!=0, VC[p] valid -> write dropped, VC[p] unchanged, overflow set at the edge.
REQ-018 full = valid of VC[p], combinational from current polarity and slot state; full=0 during reset.
REQ-019 Drain: VC[~p] valid and ready_in=1 -> at the edge send<=1, data_out<=VC[~p], VC[~p] cleared; link flit is thus presented in the following cycle, whose polarity equals ~p, matching the downstream VC.
REQ-020 Otherwise send<=0 and data_out<=64'h0 at the edge; send is never high two cycles from one slot without a new write.
REQ-021 Latency: flit written in cycle with polarity p appears on send/data_out two cycles after the write edge minimum (next p-drain cycle), assuming ready_in=1.
REQ-022 ready_in=0 holds VC[~p] content unchanged; no flit lost or duplicated.
REQ-023 Per-VC age counter: cleared when slot empty or loaded; increments each cycle slot stays valid; saturates at AGE_LIMIT.
REQ-024 Age counter reaching AGE_LIMIT sets stall_err; flit stays held and is still drained normally once ready_in returns.
REQ-025 overflow and stall_err clear only on reset.
REQ-026 Simultaneous write to VC[p] and drain of VC[~p] in one cycle both complete.
REQ-027 polarity not toggling (held constant) is legal: only one VC writable, only the other drainable; behavior per REQ-014 unchanged.

Reset
REQ-028 reset=1 at an edge: both slots cleared, age counters 0, send=0, data_out=64'h0, overflow=0, stall_err=0.
REQ-029 Reset mid-operation discards held flits; no send pulse in the cycle after reset.
REQ-030 wr_en and ready_in ignored while reset=1.

Structure
REQ-031 Shared package router_pkg holds FLIT_W=64, NUM_VC=2, EMPTY_FLIT=64'h0, default AGE_LIMIT; also used by router_input_channel.
REQ-032 One sub-module router_vc_slot (flit register, valid bit, age counter, load/clear/aged ports), instantiated twice.
REQ-033 Top level holds polarity steering, drain/write muxing, output registers and sticky flags only.

Verification
REQ-034 Reset, then polarity toggling, wr_en=1 wr_data=64'hA5 at p=0, ready_in=1 -> send=1 data_out=64'hA5 in the cycle after the next p=1 edge, once only.
REQ-035 Write 64'h11 at p=0 and 64'h22 at p=1 back-to-back, ready_in=1 -> send pulses with 64'h11 then 64'h22, one cycle apart, no loss.
REQ-036 Fill VC0 with 64'h33, second write 64'h44 at next p=0 with ready_in=0 -> full=1, overflow=1, later drain yields 64'h33 only.
REQ-037 AGE_LIMIT=4, hold flit 64'h55 with ready_in=0 for 6 cycles -> stall_err=1 after 4 held cycles; ready_in=1 -> 64'h55 sent once, stall_err stays 1.
REQ-038 wr_en=1 wr_data=64'h0 -> full stays 0, send never asserts, overflow=0.
REQ-039 Flit held, reset pulsed for one cycle -> send=0, data_out=0, full=0, all flags 0 afterward; flit never appears.
